// File: rtl/aurora_pkg.sv
// Shared Aurora 64b/66b constants: sync headers, scrambler taps, LFSR geometry and seed.
package aurora_pkg;

  // Sync header encodings
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Self-synchronous scrambler x^58 + x^39 + 1
  localparam int unsigned LFSR_WIDTH = 58;
  localparam int unsigned TAP_LO     = 38;
  localparam int unsigned TAP_HI     = 57;

  // State loaded on reset
  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 58'h3FF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/aurora_scrambler.sv
// Aurora 64b/66b TX payload scrambler (x^58 + x^39 + 1).
// Produces a registered 66-bit block {sync header, scrambled payload}; the header
// bypasses the scrambler. Payload bit 0 is scrambled first, and the LFSR state is
// made only of scrambled output bits so the far-end descrambler self-synchronises.
module aurora_scrambler
  import aurora_pkg::*;
#(
  parameter int unsigned            TX_DATA_WIDTH  = 64,  // only 64 is supported
  parameter logic [LFSR_WIDTH-1:0]  SCRAMBLER_SEED = DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TX_DATA_WIDTH-1:0]   data_in,
  input  logic [1:0]                 sync_info,
  input  logic                       enable,
  output logic [TX_DATA_WIDTH+1:0]   data_out
);

  logic [LFSR_WIDTH-1:0]     state_r;
  logic [TX_DATA_WIDTH+1:0]  data_out_r;
  logic [LFSR_WIDTH-1:0]     poly_s;
  logic [TX_DATA_WIDTH-1:0]  scrambled_s;

  // Unrolled bit-serial scramble of the whole payload from the current state
  always_comb begin
    poly_s      = state_r;
    scrambled_s = '0;
    for (int i = 0; i < TX_DATA_WIDTH; i++) begin
      scrambled_s[i] = data_in[i] ^ poly_s[TAP_LO] ^ poly_s[TAP_HI];
      poly_s         = {poly_s[LFSR_WIDTH-2:0], scrambled_s[i]};
    end
  end

  // State and output registers: reset reseeds, enable advances, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SCRAMBLER_SEED;
      data_out_r <= '0;
    end else if (enable) begin
      state_r    <= poly_s;
      data_out_r <= {sync_info, scrambled_s};
    end else begin
      state_r    <= state_r;
      data_out_r <= data_out_r;
    end
  end

  assign data_out = data_out_r;

endmodule

// File: tb/tb_aurora_scrambler.sv
// Directed self-checking bench for aurora_scrambler.
module tb_aurora_scrambler;

  logic        clk;
  logic        rst;
  logic [63:0] data_in;
  logic [1:0]  sync_info;
  logic        enable;
  logic [65:0] data_out;

  int n_cmp;
  int n_bad;

  localparam logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF;
  // Zero payload scrambled from the seed
  localparam logic [63:0] FIRST_ZERO = 64'h03FF_FF80_0000_0000;
  // Second consecutive zero payload (i.e. bits 64..127 of the zero stream)
  localparam logic [63:0] SECOND_ZERO = 64'hFFEF_FFFF_FFFF_C000;

  aurora_scrambler dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .sync_info (sync_info),
    .enable    (enable),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference descrambler: d[i] = s[i] ^ p[38] ^ p[57], p shifts in the received bit
  task automatic descramble(input logic [63:0] s, input logic [57:0] st_in,
                            output logic [63:0] d, output logic [57:0] st_out);
    logic [57:0] p;
    p = st_in;
    d = 64'h0;
    for (int i = 0; i < 64; i++) begin
      d[i] = s[i] ^ p[38] ^ p[57];
      p    = {p[56:0], s[i]};
    end
    st_out = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; data_in = 64'hDEAD_BEEF_0123_4567; sync_info = 2'b10;
    tick();
    n_cmp++;
    if (data_out !== 66'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want %h", data_out, 66'h0);
    end
  endtask

  task automatic test_first_block();
    rst = 1'b0; enable = 1'b1; data_in = 64'h0; sync_info = 2'b01;
    tick();
    n_cmp++;
    if (data_out !== {2'b01, FIRST_ZERO}) begin
      n_bad++;
      $display("FAIL first_block: got %h want %h", data_out, {2'b01, FIRST_ZERO});
    end
  endtask

  task automatic test_hold();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_in   = {32'(k * 7 + 3), 32'(~k)};
      sync_info = 2'(k);
      tick();
      n_cmp++;
      if (data_out !== {2'b01, FIRST_ZERO}) begin
        n_bad++;
        $display("FAIL hold_%0d: got %h want %h", k, data_out, {2'b01, FIRST_ZERO});
      end
    end
    // State must not have moved: next zero block continues the zero stream
    enable = 1'b1; data_in = 64'h0; sync_info = 2'b10;
    tick();
    n_cmp++;
    if (data_out !== {2'b10, SECOND_ZERO}) begin
      n_bad++;
      $display("FAIL hold_state: got %h want %h", data_out, {2'b10, SECOND_ZERO});
    end
    enable = 1'b0;
  endtask

  task automatic test_sync_passthrough();
    logic [1:0] hdr [4];
    hdr[0] = 2'b01; hdr[1] = 2'b10; hdr[2] = 2'b00; hdr[3] = 2'b11;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sync_info = hdr[k];
      data_in   = {16'h5A5A, 48'(k)};
      tick();
      n_cmp++;
      if (data_out[65:64] !== hdr[k]) begin
        n_bad++;
        $display("FAIL sync_%0d: got %b want %b", k, data_out[65:64], hdr[k]);
      end
    end
    enable = 1'b0;
  endtask

  // Stream {cnt,cnt} through the DUT and a descrambler seeded with rx_seed;
  // blocks from first_chk onward must recover exactly
  task automatic run_stream(input logic [57:0] rx_seed, input int first_chk, input string tag);
    logic [57:0] rx_st;
    logic [63:0] rec;
    int          bad_blocks;
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0;
    rx_st = rx_seed;
    bad_blocks = 0;
    enable = 1'b1;
    for (int cnt = 0; cnt <= 1000; cnt++) begin
      data_in   = {32'(cnt), 32'(cnt)};
      sync_info = cnt[0] ? 2'b10 : 2'b01;
      tick();
      descramble(data_out[63:0], rx_st, rec, rx_st);
      if (cnt >= first_chk) begin
        n_cmp++;
        if (rec !== data_in || data_out[65:64] !== sync_info) begin
          n_bad++;
          bad_blocks++;
          if (bad_blocks <= 5)
            $display("FAIL %s_blk%0d: got %h/%h want %h/%h", tag, cnt,
                     data_out[65:64], rec, sync_info, data_in);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_mid_reset();
    rst = 1'b0; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data_in = {32'hCAFE_0000 | 32'(k), 32'h1234_5678}; sync_info = 2'b01;
      tick();
    end
    rst = 1'b1; enable = 1'b1; data_in = 64'hFFFF_FFFF_FFFF_FFFF; sync_info = 2'b11;
    tick();
    n_cmp++;
    if (data_out !== 66'h0) begin
      n_bad++;
      $display("FAIL midrst_out: got %h want %h", data_out, 66'h0);
    end
    rst = 1'b0; enable = 1'b1; data_in = 64'h0; sync_info = 2'b01;
    tick();
    n_cmp++;
    if (data_out !== {2'b01, FIRST_ZERO}) begin
      n_bad++;
      $display("FAIL midrst_block: got %h want %h", data_out, {2'b01, FIRST_ZERO});
    end
    enable = 1'b0;
  endtask

  initial begin
    logic [57:0] rand_seed;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; enable = 1'b0; data_in = 64'h0; sync_info = 2'b00;
    @(negedge clk);
    test_reset();
    test_first_block();
    test_hold();
    test_sync_passthrough();
    run_stream(SEED, 0, "stream");
    rand_seed = {26'($urandom), 32'($urandom)};
    run_stream(rand_seed, 1, "resync");
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
